// File: rtl/dataflow_ctrl.sv
// dataflow_ctrl: sequencer for the dataflow lane array.
//   Accepts a (mode, tile count) command, programs dataflow mode, meters one
//   tile per cycle from the tile loader into dataflow (gated by output-buffer
//   credits), and tracks tiles through the fixed dataflow latency so each
//   output tile is flagged to the consumer.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_mode/cmd_tiles : command handshake (IDLE only)
//   src_valid/src_ready                    : tile issue handshake
//   df_mode                                : drives dataflow.mode
//   out_valid/out_last                     : output tile qualifiers
//   credit_ret                             : one output-buffer slot freed
//   busy/done/credit_err                   : status
// Optional: define DATAFLOW_CTRL_PERF_EN to add stall_cnt/busy_cnt counters.
module dataflow_ctrl #(
  parameter int LAT       = 2,
  parameter int MAX_TILES = 512,
  parameter int CREDITS   = 4,
  parameter int TW        = $clog2(MAX_TILES+1),
  parameter int CW        = $clog2(CREDITS+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_mode,
  input  logic [TW-1:0] cmd_tiles,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          df_mode,
  output logic          out_valid,
  output logic          out_last,
  input  logic          credit_ret,
  output logic          busy,
  output logic          done,
  output logic          credit_err
`ifdef DATAFLOW_CTRL_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   busy_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [TW-1:0]   tiles_q, tiles_d;
  logic [TW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic            df_mode_q, df_mode_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [LAT-1:0]  vld_q, vld_d;
  logic [LAT-1:0]  lst_q, lst_d;

  logic            accept, issue, last_issue;
  logic [TW-1:0]   tiles_clamp;

  // Handshake outputs come from registered state only; cmd_ready is also
  // forced low while reset is held.
  assign cmd_ready  = reset && (state_q == S_IDLE);
  assign src_ready  = (state_q == S_RUN) && (credits_q != '0) && (issued_q < tiles_q);
  assign accept     = cmd_valid && cmd_ready;
  assign issue      = src_valid && src_ready;
  assign last_issue = issue && (issued_q == tiles_q - TW'(1));
  assign tiles_clamp = (cmd_tiles > TW'(MAX_TILES)) ? TW'(MAX_TILES) : cmd_tiles;

  assign df_mode    = df_mode_q;
  assign out_valid  = vld_q[LAT-1];
  assign out_last   = lst_q[LAT-1];
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign credit_err = err_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tiles_d   = tiles_q;
    issued_d  = issued_q;
    credits_d = credits_q;
    df_mode_d = df_mode_q;
    err_d     = err_q;
    done_d    = (state_q == S_DONE);

    // Latency pipe: stage 0 takes this cycle's issue; the last stage is the
    // registered output pair.
    vld_d = '0;
    lst_d = '0;
    vld_d[0] = issue;
    lst_d[0] = last_issue;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end

    case (state_q)
      S_IDLE: if (accept) begin
        mode_d  = cmd_mode;
        tiles_d = tiles_clamp;
        if (tiles_clamp == '0) state_d = S_DONE;
        else begin
          // Mode goes out on entry to SETUP so it is already stable during
          // SETUP, a full cycle before the first src_ready.
          df_mode_d = cmd_mode;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        df_mode_d = mode_q;
        issued_d  = '0;
        state_d   = S_RUN;
      end
      S_RUN: if (issue) begin
        issued_d = issued_q + TW'(1);
        if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: if (vld_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Simultaneous issue and return cancel out; a return at full credit is
    // dropped and flagged.
    case ({issue, credit_ret})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CW'(CREDITS)) err_d = 1'b1;
        else                           credits_d = credits_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      tiles_q   <= '0;
      issued_q  <= '0;
      credits_q <= CW'(CREDITS);
      df_mode_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= '0;
      lst_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tiles_q   <= tiles_d;
      issued_q  <= issued_d;
      credits_q <= credits_d;
      df_mode_q <= df_mode_d;
      done_q    <= done_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      lst_q     <= lst_d;
    end
  end

`ifdef DATAFLOW_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] busy_cnt_q, busy_cnt_d;

  assign stall_cnt = stall_cnt_q;
  assign busy_cnt  = busy_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
      busy_cnt_d  = '0;
    end else begin
      if ((state_q == S_RUN) && src_valid && (credits_q == '0) && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (busy && (busy_cnt_q != '1))
        busy_cnt_d = busy_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dataflow_ctrl.sv
// Directed bench for dataflow_ctrl (LAT=2, CREDITS=4). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_dataflow_ctrl;
  localparam int TW = 10;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_mode;
  logic [TW-1:0] cmd_tiles;
  logic          src_valid, src_ready, df_mode;
  logic          out_valid, out_last, credit_ret;
  logic          busy, done, credit_err;
`ifdef DATAFLOW_CTRL_PERF_EN
  logic [31:0]   stall_cnt, busy_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dataflow_ctrl dut (
    .clk(clk), .reset(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_tiles(cmd_tiles),
    .src_valid(src_valid), .src_ready(src_ready), .df_mode(df_mode),
    .out_valid(out_valid), .out_last(out_last), .credit_ret(credit_ret),
    .busy(busy), .done(done), .credit_err(credit_err)
`ifdef DATAFLOW_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .busy_cnt(busy_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_tiles = '0;
    src_valid = 1'b0; credit_ret = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_src_ready", {31'd0, src_ready}, 32'd0);
    chk("rst_outs", {26'd0, busy, done, out_valid, out_last, df_mode, credit_err}, 32'd0);
    rst_n = 1'b1; #1;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // basic command: mode 1, 3 tiles
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_tiles = 10'd3; src_valid = 1'b1;
    tick();
    chk("setup_busy", {31'd0, busy}, 32'd1);
    chk("setup_df_mode", {31'd0, df_mode}, 32'd1);
    chk("setup_src_ready", {31'd0, src_ready}, 32'd0);
    chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    tick();
    chk("run0", {30'd0, src_ready, out_valid}, 32'b10);
    tick();
    chk("run1", {30'd0, src_ready, out_valid}, 32'b10);
    tick();
    chk("run2", {29'd0, src_ready, out_valid, out_last}, 32'b110);
    tick();
    chk("drain0", {29'd0, src_ready, out_valid, out_last}, 32'b010);
    credit_ret = 1'b1;
    tick();
    chk("drain1_last", {30'd0, out_valid, out_last}, 32'b11);
    tick();
    chk("drain2", {29'd0, out_valid, busy, done}, 32'b010);
    tick();
    credit_ret = 1'b0;
    chk("done_state", {30'd0, busy, done}, 32'b10);
    tick();
    chk("done_pulse", {28'd0, done, busy, cmd_ready, credit_err}, 32'b1010);
    tick();
    chk("done_single", {31'd0, done}, 32'd0);

    // zero tiles: done two cycles after acceptance, df_mode untouched
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_tiles = 10'd0;
    tick();
    cmd_valid = 1'b0;
    chk("zero_state", {28'd0, busy, done, src_ready, df_mode}, 32'b1001);
    tick();
    chk("zero_done", {28'd0, done, df_mode, out_valid, busy}, 32'b1100);
`ifdef DATAFLOW_CTRL_PERF_EN
    chk("zero_busy_cnt", busy_cnt, 32'd1);
`endif
    tick();
    chk("zero_done_single", {31'd0, done}, 32'd0);

    // credit stall: 6 tiles, 4 credits, no returns
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_tiles = 10'd6;
    tick();
    cmd_valid = 1'b0;
    chk("stall_setup_mode", {31'd0, df_mode}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stall_issue", {31'd0, src_ready}, 32'd1);
      tick();
    end
    chk("starved0", {31'd0, src_ready}, 32'd0);
    tick();
    chk("starved1", {31'd0, src_ready}, 32'd0);
    tick();
    chk("starved2", {31'd0, src_ready}, 32'd0);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("one_credit", {31'd0, src_ready}, 32'd1);
`ifdef DATAFLOW_CTRL_PERF_EN
    chk("stall_cnt3", stall_cnt, 32'd3);
`endif
    tick();
    chk("one_issue_only", {31'd0, src_ready}, 32'd0);
    credit_ret = 1'b1;
    tick();
    chk("one_credit2", {31'd0, src_ready}, 32'd1);
`ifdef DATAFLOW_CTRL_PERF_EN
    chk("stall_cnt4", stall_cnt, 32'd4);
`endif
    // credit_ret stays high: issue and return in the same cycle
    tick();
    chk("drain_after_6", {30'd0, src_ready, busy}, 32'b01);
    tick(); tick(); tick();
    // credits back at 4 only if the shared cycle left them unchanged
    chk("no_err_at_full", {31'd0, credit_err}, 32'd0);
    tick();
    credit_ret = 1'b0;
    chk("credit_err_set", {31'd0, credit_err}, 32'd1);
    chk("stall_cmd_done", {30'd0, done, busy}, 32'b10);

    // busy reject: second command held while the first runs
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_tiles = 10'd2;
    tick();
    cmd_mode = 1'b0; cmd_tiles = 10'd1;
    chk("rej_setup", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rej_busy", {31'd0, cmd_ready}, 32'd0);
    end
    tick();
    chk("rej_idle", {29'd0, cmd_ready, done, credit_err}, 32'b111);
    tick();
    cmd_valid = 1'b0;
    chk("held_accept", {30'd0, busy, df_mode}, 32'b10);
    tick(); tick(); tick();
    chk("held_out", {30'd0, out_valid, out_last}, 32'b11);
    wait_done("held_done");
    credit_ret = 1'b1;
    tick(); tick(); tick();
    credit_ret = 1'b0;
    chk("err_sticky", {31'd0, credit_err}, 32'd1);

    // reset mid-RUN after 2 of 5 issues
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_tiles = 10'd5;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset", {30'd0, busy, out_valid}, 32'b11);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {26'd0, busy, done, out_valid, out_last, df_mode, credit_err}, 32'd0);
    chk("async_rst_rdy", {30'd0, cmd_ready, src_ready}, 32'd0);
    tick();
    rst_n = 1'b1; src_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", {30'd0, out_valid, done}, 32'd0);
    end
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_tiles = 10'd1; src_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("post_rst_run", {31'd0, src_ready}, 32'd1);
    tick(); tick();
    chk("post_rst_out", {30'd0, out_valid, out_last}, 32'b11);
    wait_done("post_rst_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dataflow_ctrl.md
Name: dataflow_ctrl

Overview:
Sequencer for the `dataflow` lane array.
- Accepts a command (mode, tile count) and programs `dataflow` mode.
- Meters one tile per issue cycle from the upstream tile source into `dataflow`, gated by downstream buffer credits.
- Tracks tiles in flight through the fixed `dataflow` pipeline latency and flags each valid output tile to the consumer.
- Sits between the tile loader, the `dataflow` instance and the output buffer.

Parameters:
- LAT, 2: `dataflow` in-to-out latency in clk cycles; minimum 1.
- MAX_TILES, 512: maximum tiles per command.
- CREDITS, 4: downstream output-buffer slots.
- TW, $clog2(MAX_TILES+1): width of the tile count.
- CW, $clog2(CREDITS+1): width of the credit counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller accepts a command (IDLE only).
- cmd_mode  in  1  `dataflow` mode for this command.
- cmd_tiles  in  TW  number of tiles to process; 0 is legal.
- src_valid  in  1  tile present on the `dataflow` input bus.
- src_ready  out  1  tile consumed this cycle when src_valid is also high.
- df_mode  out  1  drives `dataflow.mode`.
- out_valid  out  1  `dataflow` output bus holds a valid tile this cycle.
- out_last  out  1  qualifies out_valid: this is the final tile of the command.
- credit_ret  in  1  one buffer slot freed by the consumer.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at command completion.
- credit_err  out  1  sticky: credit returned while credits==CREDITS.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; df_mode=0; out_valid=0; out_last=0; done=0; busy=0; credit_err=0.
  - credits=CREDITS; issued=0; latency pipe cleared.
  - cmd_ready=0 and src_ready=0 while reset is asserted.
- Reset mid-command aborts immediately. Tiles in flight are discarded and no done pulse is produced.
- States: IDLE, SETUP, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_mode and cmd_tiles.
  - cmd_tiles==0 -> DONE; otherwise -> SETUP.
- SETUP (exactly 1 cycle):
  - df_mode <= latched mode; issued <= 0.
  - -> RUN. df_mode is therefore stable for at least one cycle before the first issue.
- RUN:
  - src_ready = (credits!=0) && (issued<tiles). src_ready is combinational from registered state only; it never depends on src_valid.
  - Issue = src_valid&&src_ready. Each issue increments issued and decrements credits.
  - On the issue where issued==tiles-1 -> DRAIN.
- DRAIN:
  - src_ready=0.
  - -> DONE once the latency pipe holds no valid entry and no output is presented this cycle.
- DONE:
  - done=1 for one cycle; -> IDLE.
  - df_mode holds its value after DONE until the next SETUP.
- Latency pipe:
  - LAT-deep shift of {valid,last} pairs; an issue enters stage 0.
  - out_valid/out_last are driven from stage LAT-1, registered. An issue in cycle t gives out_valid in cycle t+LAT.
  - out_last is asserted only with out_valid.
- Credits:
  - Issue and credit_ret in the same cycle leave credits unchanged.
  - credit_ret alone increments credits, saturating at CREDITS.
  - credit_ret at CREDITS is ignored and sets credit_err (sticky until reset).
  - credit_ret is honoured in every state, including IDLE.
- Commands:
  - cmd_valid outside IDLE is not accepted; cmd_ready=0 and the requester holds.
  - cmd_tiles>MAX_TILES is clamped to MAX_TILES.
- Arithmetic: counters are unsigned and never wrap. issued is bounded by tiles; credits is bounded by 0..CREDITS.

Optional Feature:
- Macro: DATAFLOW_CTRL_PERF_EN.
- With the macro defined:
  - Adds output stall_cnt [31:0], counting RUN cycles with src_valid=1 and credits==0.
  - Adds output busy_cnt [31:0], counting cycles with busy=1.
  - Both counters are cleared by reset and by command acceptance, saturate at all-ones, and hold their value in IDLE.
- Without the macro: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Basic command: after reset release, cmd mode=1 tiles=3, src_valid held high, credit_ret pulsed one cycle after each out_valid -> df_mode=1 one cycle before the first src_ready. Exactly 3 issues; out_valid LAT=2 cycles after each issue; out_last on the 3rd only; single done pulse; busy drops with return to IDLE.
- Credit stall: CREDITS=4, tiles=6, no credit_ret -> 4 issues, then src_ready=0 indefinitely. One credit_ret -> exactly one more issue. Issue and credit_ret in the same cycle keep credits unchanged.
- Zero tiles: cmd tiles=0 -> no src_ready, no out_valid, done 2 cycles after acceptance, df_mode unchanged.
- Credit error: credit_ret while credits==4 -> credit_err=1 and stays 1 across later commands until reset.
- Reset mid-RUN after 2 of 5 issues -> all outputs reach reset values asynchronously, no done pulse, no out_valid after release. A new cmd tiles=1 then completes normally.
- Busy reject: cmd_valid held during RUN -> cmd_ready=0 until IDLE; the held command is accepted on the first IDLE cycle. With DATAFLOW_CTRL_PERF_EN defined, stall_cnt equals the number of credit-starved cycles.
